// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder-buffer retire controller.
package rob_pkg;

  localparam int ROB_DEPTH      = 4096;
  localparam int ROB_AW         = $clog2(ROB_DEPTH);
  localparam int ROB_DW         = 512;
  localparam int ROB_RD_LAT     = 2;
  localparam int ROB_FIFO_DEPTH = ROB_RD_LAT + 2;
  localparam int ROB_CW         = $clog2(ROB_FIFO_DEPTH + 1);

  typedef logic [ROB_AW-1:0] rob_tag_t;
  typedef logic [ROB_DW-1:0] rob_data_t;
  typedef logic [ROB_AW:0]   rob_occ_t;
  typedef logic [ROB_CW-1:0] rob_credit_t;

  // Tags wrap DEPTH-1 -> 0 naturally because DEPTH is a power of two.
  function automatic rob_tag_t rob_tag_next(rob_tag_t t);
    return t + rob_tag_t'(1);
  endfunction

endpackage

// File: rtl/rob_retire_ctrl_if.sv
// Allocation, completion, storage-read and retire-stream signals of the ROB retire controller.
interface rob_retire_ctrl_if;
  import rob_pkg::*;

  logic      alloc_req;
  logic      alloc_gnt;
  rob_tag_t  alloc_tag;
  logic      cmpl_valid;
  rob_tag_t  cmpl_tag;
  rob_tag_t  rob_rd_addr;
  rob_data_t rob_rd_data;
  logic      out_valid;
  rob_data_t out_data;
  logic      out_ready;
  rob_occ_t  occupancy;
  logic      err_dup;

  modport master (
    output alloc_req, cmpl_valid, cmpl_tag, rob_rd_data, out_ready,
    input  alloc_gnt, alloc_tag, rob_rd_addr, out_valid, out_data, occupancy, err_dup
  );

  modport slave (
    input  alloc_req, cmpl_valid, cmpl_tag, rob_rd_data, out_ready,
    output alloc_gnt, alloc_tag, rob_rd_addr, out_valid, out_data, occupancy, err_dup
  );

endinterface

// File: rtl/rob_retire_ctrl_out_fifo.sv
// First-word-fall-through output FIFO; overflow is prevented by the parent's credit counter.
module rob_out_fifo #(
  parameter int DW    = 512,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic          empty_o,
  output logic [DW-1:0] pop_data_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [DW-1:0] mem_q [DEPTH];
  ptr_t          wr_ptr_q, wr_ptr_d;
  ptr_t          rd_ptr_q, rd_ptr_d;
  cnt_t          count_q, count_d;
  logic          do_pop;

  function automatic ptr_t ptr_next(ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign empty_o    = (count_q == '0);
  assign do_pop     = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = ptr_next(wr_ptr_q);
    if (do_pop) rd_ptr_d = ptr_next(rd_ptr_q);
    count_d = count_q + cnt_t'(push_i) - cnt_t'(do_pop);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the data array is deliberately not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/rob_retire_ctrl.sv
// In-order retire side of the reorder buffer: tag allocation, done bitmap, credited reads, FWFT output.
// Optional ROB_STATS_EN adds retire_cnt / stall_cnt statistics outputs.
module rob_retire_ctrl
  import rob_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  rob_retire_ctrl_if.slave  bus
`ifdef ROB_STATS_EN
  ,
  output logic [31:0]       retire_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  rob_tag_t               head_q, head_d;
  rob_tag_t               tail_q, tail_d;
  rob_occ_t               occ_q, occ_d;
  logic [ROB_DEPTH-1:0]   done_q, done_d;
  rob_credit_t            credits_q, credits_d;
  logic [ROB_RD_LAT-1:0]  pipe_q, pipe_d;
  logic                   err_dup_q, err_dup_d;

  logic full, grant, rd_issue, push, pop, fifo_empty;

  // Full is judged on the registered occupancy, so an issue in the same cycle cannot free a grant.
  assign full     = (occ_q == rob_occ_t'(ROB_DEPTH));
  assign grant    = bus.alloc_req & ~full;
  assign rd_issue = done_q[head_q] & (credits_q != '0);
  assign push     = pipe_q[ROB_RD_LAT-1];
  assign pop      = ~fifo_empty & bus.out_ready;

  assign bus.alloc_gnt   = grant;
  assign bus.alloc_tag   = tail_q;
  assign bus.rob_rd_addr = head_q;
  assign bus.out_valid   = ~fifo_empty;
  assign bus.occupancy   = occ_q;
  assign bus.err_dup     = err_dup_q;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    occ_d     = occ_q;
    done_d    = done_q;
    err_dup_d = err_dup_q;

    if (grant)    tail_d = rob_tag_next(tail_q);
    if (rd_issue) head_d = rob_tag_next(head_q);

    if (grant && !rd_issue)      occ_d = occ_q + rob_occ_t'(1);
    else if (!grant && rd_issue) occ_d = occ_q - rob_occ_t'(1);

    // A repeated completion only raises the flag; the bitmap keeps its current value.
    if (bus.cmpl_valid) begin
      if (done_q[bus.cmpl_tag]) err_dup_d = 1'b1;
      else                      done_d[bus.cmpl_tag] = 1'b1;
    end
    if (rd_issue) done_d[head_q] = 1'b0;

    credits_d = credits_q - rob_credit_t'(rd_issue) + rob_credit_t'(pop);
    pipe_d    = (pipe_q << 1) | ROB_RD_LAT'(rd_issue);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      occ_q     <= '0;
      done_q    <= '0;
      credits_q <= rob_credit_t'(ROB_FIFO_DEPTH);
      pipe_q    <= '0;
      err_dup_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      occ_q     <= occ_d;
      done_q    <= done_d;
      credits_q <= credits_d;
      pipe_q    <= pipe_d;
      err_dup_q <= err_dup_d;
    end
  end

  rob_out_fifo #(
    .DW    (ROB_DW),
    .DEPTH (ROB_FIFO_DEPTH)
  ) u_out_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (bus.rob_rd_data),
    .pop_i       (pop),
    .empty_o     (fifo_empty),
    .pop_data_o  (bus.out_data)
  );

`ifdef ROB_STATS_EN
  logic [31:0] retire_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall = done_q[head_q] & (credits_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (pop) retire_cnt_q <= retire_cnt_q + 32'd1;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Directed bench for rob_retire_ctrl with a behavioural RD_LAT-cycle ROB storage model.
module tb_rob_retire_ctrl;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_retire_ctrl_if bus ();

`ifdef ROB_STATS_EN
  logic [31:0] retire_cnt, stall_cnt;
`endif

  rob_retire_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ROB_STATS_EN
    ,
    .retire_cnt (retire_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] salt = 16'h0000;

  function automatic rob_data_t slot_data(rob_tag_t tag, logic [15:0] s);
    logic [31:0] w;
    w = {s, 4'h0, tag};
    return {16{w}};
  endfunction

  // Storage: completions write the slot, reads return two clocks after the address is presented.
  rob_data_t mem [ROB_DEPTH];
  rob_data_t rd_s1, rd_s2;
  always @(posedge clk) begin
    if (bus.cmpl_valid) mem[bus.cmpl_tag] <= slot_data(bus.cmpl_tag, salt);
    rd_s1 <= mem[bus.rob_rd_addr];
    rd_s2 <= rd_s1;
  end
  assign bus.rob_rd_data = rd_s2;

  task automatic check(input string name, input rob_data_t act, input rob_data_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_req  = 1'b0;
    bus.cmpl_valid = 1'b0;
    bus.cmpl_tag   = '0;
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check({tag, ".gnt"},     bus.alloc_gnt, 0);
    check({tag, ".tag"},     bus.alloc_tag, 0);
    check({tag, ".ov"},      bus.out_valid, 0);
    check({tag, ".addr"},    bus.rob_rd_addr, 0);
    check({tag, ".err_dup"}, bus.err_dup, 0);
    check({tag, ".occ"},     bus.occupancy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic alloc_n(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      bus.alloc_req = 1'b1;
      #1;
      check($sformatf("alloc%0d", first + i), {bus.alloc_gnt, bus.alloc_tag},
            {1'b1, rob_tag_t'(first + i)});
      tick();
    end
    bus.alloc_req = 1'b0;
  endtask

  task automatic complete(input rob_tag_t tag);
    bus.cmpl_valid = 1'b1;
    bus.cmpl_tag   = tag;
    tick();
    bus.cmpl_valid = 1'b0;
  endtask

  task automatic drain(input int first, input int n, input int budget, input bit contiguous,
                       input logic [15:0] s);
    int got = 0;
    int waited = 0;
    bit gap = 1'b0;
    bus.out_ready = 1'b1;
    while (got < n && waited < budget) begin
      #1;
      if (bus.out_valid) begin
        check($sformatf("drain.beat%0d", got), bus.out_data, slot_data(rob_tag_t'(first + got), s));
        got++;
      end else if (got > 0) begin
        gap = 1'b1;
      end
      tick();
      waited++;
    end
    check("drain.count", got, n);
    if (contiguous) check("drain.back_to_back", gap, 0);
  endtask

  task automatic quiet(input int n, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    check(name, seen, 0);
  endtask

  typedef struct {
    logic areq;
    logic cv;
    int   ctag;
    logic rdy;
    logic exp_gnt;
    int   exp_tag;
    int   exp_addr;
    int   exp_occ;
    logic exp_ov;
    int   exp_dtag;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // In-order flow, one row per cycle: inputs, then expected state seen during that cycle.
    vecs[0]  = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 0, 0, 0, 1'b0, 0};
    vecs[1]  = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 1, 0, 1, 1'b0, 0};
    vecs[2]  = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 2, 0, 2, 1'b0, 0};
    vecs[3]  = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 3, 0, 3, 1'b0, 0};
    vecs[4]  = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 4, 0, 4, 1'b0, 0};
    vecs[5]  = '{1'b0, 1'b1, 1, 1'b1, 1'b0, 4, 0, 4, 1'b0, 0};
    vecs[6]  = '{1'b0, 1'b1, 2, 1'b1, 1'b0, 4, 1, 3, 1'b0, 0};
    vecs[7]  = '{1'b0, 1'b1, 3, 1'b1, 1'b0, 4, 2, 2, 1'b0, 0};
    vecs[8]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 4, 3, 1, 1'b1, 0};
    vecs[9]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 4, 4, 0, 1'b1, 1};
    vecs[10] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 4, 4, 0, 1'b1, 2};
    vecs[11] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 4, 4, 0, 1'b1, 3};
    vecs[12] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 4, 4, 0, 1'b0, 0};

    do_reset("rst1");
    salt = 16'hA001;
    for (int i = 0; i < 13; i++) begin
      bus.alloc_req  = vecs[i].areq;
      bus.cmpl_valid = vecs[i].cv;
      bus.cmpl_tag   = rob_tag_t'(vecs[i].ctag);
      bus.out_ready  = vecs[i].rdy;
      #1;
      check($sformatf("v%0d.gnt", i),  bus.alloc_gnt,   vecs[i].exp_gnt);
      check($sformatf("v%0d.tag", i),  bus.alloc_tag,   vecs[i].exp_tag);
      check($sformatf("v%0d.addr", i), bus.rob_rd_addr, vecs[i].exp_addr);
      check($sformatf("v%0d.occ", i),  bus.occupancy,   vecs[i].exp_occ);
      check($sformatf("v%0d.ov", i),   bus.out_valid,   vecs[i].exp_ov);
      if (vecs[i].exp_ov)
        check($sformatf("v%0d.data", i), bus.out_data, slot_data(rob_tag_t'(vecs[i].exp_dtag), salt));
      tick();
    end
    idle_inputs();
`ifdef ROB_STATS_EN
    check("stats.retire_inorder", retire_cnt, 4);
`endif

    // Reverse completion order: nothing retires until tag 0, then 8 back-to-back beats.
    do_reset("rst2");
    salt = 16'hA002;
    bus.out_ready = 1'b1;
    alloc_n(8, 0);
    for (int t = 7; t >= 1; t--) begin
      complete(rob_tag_t'(t));
      #1;
      check($sformatf("rev.ov_after_cmpl%0d", t), bus.out_valid, 0);
    end
    quiet(6, "rev.no_early_ov");
    complete('0);
    drain(0, 8, 30, 1'b1, salt);
    #1;
    check("rev.end_occ", bus.occupancy, 0);
    check("rev.end_ov", bus.out_valid, 0);

    // Back-pressure: only RD_LAT+2 reads may issue while out_ready is low.
    do_reset("rst3");
    salt = 16'hA003;
    alloc_n(10, 0);
    for (int t = 0; t < 10; t++) complete(rob_tag_t'(t));
    repeat (10) tick();
    check("bp.occ_stalled", bus.occupancy, 6);
    check("bp.ov", bus.out_valid, 1);
    check("bp.head_data", bus.out_data, slot_data('0, salt));
    tick();
    check("bp.occ_still", bus.occupancy, 6);
    drain(0, 10, 60, 1'b0, salt);
    #1;
    check("bp.end_occ", bus.occupancy, 0);
    quiet(8, "bp.no_dup");
`ifdef ROB_STATS_EN
    check("stats.retire_bp", retire_cnt, 10);
    check("stats.stall_seen", stall_cnt != 32'd0, 1);
`endif

    // Full and wrap: refuse grant at DEPTH, even in the cycle an issue frees a slot.
    do_reset("rst4");
    salt = 16'hA004;
    bus.out_ready = 1'b1;
    alloc_n(ROB_DEPTH, 0);
    bus.alloc_req = 1'b1;
    #1;
    check("full.gnt", bus.alloc_gnt, 0);
    check("full.occ", bus.occupancy, ROB_DEPTH);
    bus.cmpl_valid = 1'b1;
    bus.cmpl_tag   = '0;
    tick();
    bus.cmpl_valid = 1'b0;
    #1;
    check("full_issue.gnt", bus.alloc_gnt, 0);
    check("full_issue.addr", bus.rob_rd_addr, 0);
    tick();
    check("wrap.gnt_tag", {bus.alloc_gnt, bus.alloc_tag}, {1'b1, rob_tag_t'(0)});
    check("wrap.occ", bus.occupancy, ROB_DEPTH - 1);
    tick();
    bus.alloc_req = 1'b0;
    check("wrap.occ_refull", bus.occupancy, ROB_DEPTH);
    drain(0, 1, 10, 1'b0, 16'hA004);
    salt = 16'hB0B0;
    fork
      begin
        for (int t = 1; t < ROB_DEPTH; t++) complete(rob_tag_t'(t));
        complete('0);
      end
      drain(1, ROB_DEPTH, ROB_DEPTH + 64, 1'b0, 16'hB0B0);
    join
    #1;
    check("wrap.end_occ", bus.occupancy, 0);
    check("wrap.end_ov", bus.out_valid, 0);

    // Duplicate completion: sticky error, slot still retired exactly once.
    do_reset("rst5");
    salt = 16'hA005;
    bus.out_ready = 1'b1;
    alloc_n(8, 0);
    complete(rob_tag_t'(5));
    #1;
    check("dup.err_before", bus.err_dup, 0);
    complete(rob_tag_t'(5));
    #1;
    check("dup.err_set", bus.err_dup, 1);
    fork
      begin
        for (int t = 0; t < 8; t++) if (t != 5) complete(rob_tag_t'(t));
      end
      drain(0, 8, 40, 1'b0, 16'hA005);
    join
    #1;
    check("dup.err_held", bus.err_dup, 1);
    check("dup.end_occ", bus.occupancy, 0);
    quiet(6, "dup.once");

    // Reset with reads still in the return path and data queued.
    do_reset("rst6");
    salt = 16'hA006;
    alloc_n(4, 0);
    complete('0);
    complete(rob_tag_t'(1));
    complete(rob_tag_t'(2));
    tick();
    check("mid.ov_before", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid.ov", bus.out_valid, 0);
    check("mid.occ", bus.occupancy, 0);
    check("mid.tag", bus.alloc_tag, 0);
    check("mid.addr", bus.rob_rd_addr, 0);
`ifdef ROB_STATS_EN
    check("stats.retire_rst", retire_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    quiet(8, "mid.dropped");
    check("mid.occ_after", bus.occupancy, 0);
    salt = 16'hA066;
    alloc_n(1, 0);
    complete('0);
    drain(0, 1, 12, 1'b0, 16'hA066);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
